jtcps2_ba0_arb: RTL and testbench
=================================

// Module: jtcps2_ba0_arb
// PURPOSE
//  Arbitrates SDRAM bank 0 (the only R/W bank) between main-CPU work RAM/VRAM accesses and
//  video VRAM DMA reads. Sits between the CPS2 main CPU, video DMA ports and the bank-0 SDRAM
//  controller interface. Runs in the SDRAM clock domain.
//  Priority: fixed DMA-first, with an anti-starvation limit for the CPU.
// PARAMETERS
//  RAM_OFS   22'h10_0000  word offset of 64kW main work RAM in bank 0
//  VRAM_OFS  22'h12_0000  word offset of VRAM in bank 0 (CPU and DMA)
//  STARVE    3            max consecutive DMA grants while CPU pending (1..7)
// PORTS
//  clk            in   1   SDRAM clock
//  rst            in   1   async reset, active-high
//  main_ram_cs    in   1   CPU work-RAM select, held until main_ok
//  main_vram_cs   in   1   CPU VRAM select, held until main_ok
//  main_addr      in   17  CPU word address [17:1]
//  main_rnw       in   1   1=read 0=write
//  main_dsn       in   2   byte strobes, active low
//  main_dout      in   16  CPU write data
//  main_data      out  16  CPU read data
//  main_ok        out  1   CPU access done (level)
//  dma_cs         in   1   video DMA read request
//  dma_addr       in   17  DMA word address [17:1]
//  dma_data       out  16  DMA read data
//  dma_ok         out  1   DMA access done (level)
//  ba0_addr       out  22  SDRAM word address
//  ba0_rd/ba0_wr  out  1   request strobes, held until ba0_ack
//  ba0_din        out  16  write data;  ba0_din_m out 2 write mask (=main_dsn)
//  ba0_ack        in   1   request accepted (1-cycle pulse)
//  ba0_rdy        in   1   access finished (1-cycle pulse); data_read valid same cycle
//  data_read      in   16  SDRAM read data
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, starve counter 0, latches cleared.
//  Request: CPU pending = (ram_cs|vram_cs) & ~main_ok; DMA pending = dma_cs & ~dma_ok.
//  ok is a level: set on the rdy cycle+1, held while cs stays high and addr unchanged;
//   cleared the cycle after cs drops or addr differs from latched addr (new transaction).
//  FSM IDLE -> REQ -> WAIT_RDY -> IDLE.
//   IDLE: grant; latch requester, addr, rnw, dsn, dout; drive ba0_rd/ba0_wr next cycle (REQ).
//   REQ: hold strobe+addr; on ba0_ack drop strobe -> WAIT_RDY.
//   WAIT_RDY: on ba0_rdy capture data_read into granted requester's data reg, set its ok,
//    return IDLE. Minimum turnaround: 3 clocks after rdy to next strobe? No: next strobe
//    asserted 1 clock after IDLE grant.
//  Grant: DMA wins unless CPU pending and starve count==STARVE. Counter increments per DMA
//   grant while CPU pending, clears on CPU grant or when CPU not pending.
//  Simultaneous ram_cs and vram_cs: ram_cs takes precedence (illegal, no error flag).
//  Address: ba0_addr = (vram ? VRAM_OFS : RAM_OFS) + {5'd0,addr}; DMA always VRAM_OFS.
//  Writes: only CPU; DMA is read-only. ba0_din_m = latched dsn.
//  cs dropped mid-transaction: transaction completes on SDRAM; ok not set; data discarded.
//  Reset mid-transaction: abort immediately; controller tolerates stray ack/rdy after reset.
//  ack and rdy in same cycle: treat as ack then rdy (go straight to IDLE with data).
// CONFIGURATION
//  JTCPS2_BA0_CACHE_EN defined: 1-entry CPU read cache (addr+space+data). CPU read hitting a
//   valid entry sets main_ok next cycle without SDRAM access. Entry invalidated by any CPU
//   write to same word, and by reset. Not defined: every CPU read goes to SDRAM.
// STRUCTURE
//  Package jtcps2_ba0_pkg: FSM state enum, requester-id enum (REQ_CPU, REQ_DMA), width consts.
//  Sub-module jtcps2_ba0_starve: starvation counter + grant decision (combinational grant
//  out, registered count). Cache logic inline under macro.
// TESTING
//  1 CPU read RAM addr 0x0040 alone, ack +2, rdy +4 data 0xBEEF -> ba0_addr 0x100040,
//    main_data 0xBEEF, main_ok rises cycle after rdy.
//  2 CPU write VRAM 0x0010 dsn=2'b01 dout 0x1234 -> ba0_wr=1, ba0_addr 0x120010,
//    ba0_din_m 2'b01, ba0_din 0x1234; main_ok after rdy.
//  3 DMA continuous + CPU pending, STARVE=3 -> grants DMA,DMA,DMA,CPU, repeat.
//  4 CPU drops cs while WAIT_RDY -> no main_ok, next grant normal; dma_data untouched.
//  5 Async rst asserted in REQ -> ba0_rd=0 same cycle, ok=0; stray rdy after release ignored.
//  6 CACHE_EN: read 0x0040 twice -> one ba0_rd; write 0x0040 then read -> new ba0_rd.

Source files
------------

// File: rtl/jtcps2_ba0_pkg.sv
// Shared types and widths for the CPS2 SDRAM bank-0 arbiter.
package jtcps2_ba0_pkg;

  localparam int unsigned AW  = 17;  // CPU/DMA word address width
  localparam int unsigned SAW = 22;  // SDRAM word address width
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 3;   // starvation counter width

  typedef enum logic [1:0] {StIdle, StReq, StWaitRdy} ba0_st_e;

  typedef enum logic {REQ_CPU, REQ_DMA} req_id_e;

  function automatic logic [SAW-1:0] ba0_map(input logic [SAW-1:0] ofs,
                                             input logic [AW-1:0]  addr);
    return ofs + {{(SAW-AW){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/jtcps2_ba0_starve.sv
// Grant decision for bank 0: DMA first, but the CPU wins once it has watched
// STARVE consecutive DMA grants go by.
module jtcps2_ba0_starve
  import jtcps2_ba0_pkg::*;
#(
  parameter int unsigned STARVE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_pend,
  input  logic dma_pend,
  input  logic arb_en,
  output logic gnt_cpu,
  output logic gnt_dma
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cpu_turn;

  always_comb begin
    cpu_turn = cpu_pend && (cnt_q == CW'(STARVE));
    gnt_dma  = arb_en & dma_pend & ~cpu_turn;
    gnt_cpu  = arb_en & cpu_pend & ~gnt_dma;
    cnt_d    = cnt_q;
    if (!cpu_pend || gnt_cpu) begin
      cnt_d = '0;
    end else if (gnt_dma && (cnt_q != CW'(STARVE))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jtcps2_ba0_arb.sv
// SDRAM bank-0 arbiter between CPU work RAM/VRAM and video DMA reads.
// Optional 1-entry CPU read cache enabled by defining JTCPS2_BA0_CACHE_EN.
module jtcps2_ba0_arb
  import jtcps2_ba0_pkg::*;
#(
  parameter logic [21:0] RAM_OFS  = 22'h10_0000,
  parameter logic [21:0] VRAM_OFS = 22'h12_0000,
  parameter int unsigned STARVE   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        main_ram_cs,
  input  logic        main_vram_cs,
  input  logic [16:0] main_addr,
  input  logic        main_rnw,
  input  logic [1:0]  main_dsn,
  input  logic [15:0] main_dout,
  output logic [15:0] main_data,
  output logic        main_ok,
  input  logic        dma_cs,
  input  logic [16:0] dma_addr,
  output logic [15:0] dma_data,
  output logic        dma_ok,
  output logic [21:0] ba0_addr,
  output logic        ba0_rd,
  output logic        ba0_wr,
  output logic [15:0] ba0_din,
  output logic [1:0]  ba0_din_m,
  input  logic        ba0_ack,
  input  logic        ba0_rdy,
  input  logic [15:0] data_read
);

  ba0_st_e       state_q, state_d;
  req_id_e       req_q;
  logic          rnw_q;
  logic [1:0]    dsn_q;
  logic [DW-1:0] din_q;
  logic [SAW-1:0] addr_q;
  logic [AW-1:0] cpu_addr_q, dma_addr_q;
  logic          cpu_vram_q;
  logic          main_ok_q, main_ok_d, dma_ok_q, dma_ok_d;
  logic [DW-1:0] main_data_q, main_data_d, dma_data_q, dma_data_d;

  logic cpu_cs, cpu_vram, cpu_new, cpu_keep, cpu_pend, cpu_arb;
  logic dma_new, dma_keep, dma_pend;
  logic arb_en, gnt_cpu, gnt_dma, done;
  logic hit, cache_serve;
  logic [DW-1:0] hit_data;

  // ram_cs wins if both selects are (illegally) high together
  assign cpu_cs   = main_ram_cs | main_vram_cs;
  assign cpu_vram = ~main_ram_cs & main_vram_cs;
  assign cpu_new  = (main_addr != cpu_addr_q) || (cpu_vram != cpu_vram_q);
  assign cpu_keep = cpu_cs & ~cpu_new;
  assign cpu_pend = cpu_cs & (~main_ok_q | cpu_new);
  assign dma_new  = dma_addr != dma_addr_q;
  assign dma_keep = dma_cs & ~dma_new;
  assign dma_pend = dma_cs & (~dma_ok_q | dma_new);

  assign arb_en      = state_q == StIdle;
  assign cpu_arb     = cpu_pend & ~hit;
  assign cache_serve = arb_en & cpu_pend & hit;
  // ack and rdy together count as ack followed by rdy
  assign done = ba0_rdy & (((state_q == StReq) & ba0_ack) | (state_q == StWaitRdy));

  jtcps2_ba0_starve #(
    .STARVE (STARVE)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .cpu_pend (cpu_arb),
    .dma_pend (dma_pend),
    .arb_en   (arb_en),
    .gnt_cpu  (gnt_cpu),
    .gnt_dma  (gnt_dma)
  );

`ifdef JTCPS2_BA0_CACHE_EN
  logic          cache_vld_q, cache_vram_q;
  logic [AW-1:0] cache_addr_q;
  logic [DW-1:0] cache_data_q;

  assign hit = cache_vld_q && (cache_addr_q == main_addr) && (cache_vram_q == cpu_vram) &&
               main_rnw;
  assign hit_data = cache_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_q  <= 1'b0;
      cache_vram_q <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
    end else if (gnt_cpu && !main_rnw && (main_addr == cache_addr_q) &&
                 (cpu_vram == cache_vram_q)) begin
      cache_vld_q <= 1'b0;
    end else if (done && (req_q == REQ_CPU) && rnw_q && cpu_keep) begin
      cache_vld_q  <= 1'b1;
      cache_vram_q <= cpu_vram_q;
      cache_addr_q <= cpu_addr_q;
      cache_data_q <= data_read;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (gnt_cpu || gnt_dma) state_d = StReq;
      StReq:     if (ba0_ack) state_d = ba0_rdy ? StIdle : StWaitRdy;
      StWaitRdy: if (ba0_rdy) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ba0_rd    = (state_q == StReq) & rnw_q;
    ba0_wr    = (state_q == StReq) & ~rnw_q;
    ba0_addr  = addr_q;
    ba0_din   = din_q;
    ba0_din_m = dsn_q;
    main_ok   = main_ok_q;
    main_data = main_data_q;
    dma_ok    = dma_ok_q;
    dma_data  = dma_data_q;
  end

  // ok drops once the requester moves on; a withdrawn request never sets it
  always_comb begin
    main_ok_d   = main_ok_q & cpu_keep;
    main_data_d = main_data_q;
    dma_ok_d    = dma_ok_q & dma_keep;
    dma_data_d  = dma_data_q;
    if (done && (req_q == REQ_CPU) && cpu_keep) begin
      main_ok_d = 1'b1;
      if (rnw_q) main_data_d = data_read;
    end
    if (cache_serve) begin
      main_ok_d   = 1'b1;
      main_data_d = hit_data;
    end
    if (done && (req_q == REQ_DMA) && dma_keep) begin
      dma_ok_d   = 1'b1;
      dma_data_d = data_read;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= REQ_CPU;
      rnw_q       <= 1'b0;
      dsn_q       <= '0;
      din_q       <= '0;
      addr_q      <= '0;
      cpu_addr_q  <= '0;
      cpu_vram_q  <= 1'b0;
      dma_addr_q  <= '0;
      main_ok_q   <= 1'b0;
      main_data_q <= '0;
      dma_ok_q    <= 1'b0;
      dma_data_q  <= '0;
    end else begin
      if (gnt_dma) begin
        req_q  <= REQ_DMA;
        rnw_q  <= 1'b1;
        dsn_q  <= '0;
        din_q  <= '0;
        addr_q <= ba0_map(VRAM_OFS, dma_addr);
      end else if (gnt_cpu) begin
        req_q  <= REQ_CPU;
        rnw_q  <= main_rnw;
        dsn_q  <= main_dsn;
        din_q  <= main_dout;
        addr_q <= ba0_map(cpu_vram ? VRAM_OFS : RAM_OFS, main_addr);
      end
      if (gnt_cpu || cache_serve) begin
        cpu_addr_q <= main_addr;
        cpu_vram_q <= cpu_vram;
      end
      if (gnt_dma) dma_addr_q <= dma_addr;
      main_ok_q   <= main_ok_d;
      main_data_q <= main_data_d;
      dma_ok_q    <= dma_ok_d;
      dma_data_q  <= dma_data_d;
    end
  end

endmodule

// File: tb/tb_jtcps2_ba0_arb.sv
// Directed bench for jtcps2_ba0_arb with a small SDRAM controller responder.
`timescale 1ns/1ps
module tb_jtcps2_ba0_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        main_ram_cs, main_vram_cs, main_rnw;
  logic [16:0] main_addr;
  logic [1:0]  main_dsn;
  logic [15:0] main_dout, main_data;
  logic        main_ok;
  logic        dma_cs, dma_ok;
  logic [16:0] dma_addr;
  logic [15:0] dma_data;
  logic [21:0] ba0_addr;
  logic        ba0_rd, ba0_wr, ba0_ack, ba0_rdy;
  logic [15:0] ba0_din, data_read;
  logic [1:0]  ba0_din_m;

  jtcps2_ba0_arb dut (
    .clk          (clk),
    .rst          (rst),
    .main_ram_cs  (main_ram_cs),
    .main_vram_cs (main_vram_cs),
    .main_addr    (main_addr),
    .main_rnw     (main_rnw),
    .main_dsn     (main_dsn),
    .main_dout    (main_dout),
    .main_data    (main_data),
    .main_ok      (main_ok),
    .dma_cs       (dma_cs),
    .dma_addr     (dma_addr),
    .dma_data     (dma_data),
    .dma_ok       (dma_ok),
    .ba0_addr     (ba0_addr),
    .ba0_rd       (ba0_rd),
    .ba0_wr       (ba0_wr),
    .ba0_din      (ba0_din),
    .ba0_din_m    (ba0_din_m),
    .ba0_ack      (ba0_ack),
    .ba0_rdy      (ba0_rdy),
    .data_read    (data_read)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // SDRAM responder: ack/rdy land ack_dly/rdy_dly edges after the strobe edge
  int          ack_dly = 1;
  int          rdy_dly = 2;
  logic [15:0] rd_val  = 16'h0;
  bit          resp_en = 1'b1;
  logic [21:0] log_q[$];

  initial begin : sdram
    ba0_ack = 1'b0;
    ba0_rdy = 1'b0;
    data_read = 16'h0;
    forever begin
      @(negedge clk);
      if (resp_en && !rst && (ba0_rd || ba0_wr)) begin
        log_q.push_back(ba0_addr);
        for (int k = 1; k <= rdy_dly; k++) begin
          ba0_ack   = (k == ack_dly);
          ba0_rdy   = (k == rdy_dly);
          data_read = ba0_rdy ? rd_val : 16'h0;
          if (k < rdy_dly) @(negedge clk);
        end
        @(negedge clk);
        ba0_ack = 1'b0;
        ba0_rdy = 1'b0;
        data_read = 16'h0;
      end
    end
  end

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ba0_rd || ba0_wr) && n < 50);
    check(tag, 32'(ba0_rd | ba0_wr), 32'd1);
  endtask

  task automatic wait_main_ok(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!main_ok && n < 50);
    check(tag, 32'(main_ok), 32'd1);
  endtask

  task automatic do_cpu(input string tag, input logic vram, input logic [16:0] a,
                        input logic rnw, input logic [1:0] dsn, input logic [15:0] dout);
    @(posedge clk); #1;
    main_ram_cs = ~vram;
    main_vram_cs = vram;
    main_addr = a;
    main_rnw = rnw;
    main_dsn = dsn;
    main_dout = dout;
    wait_main_ok(tag);
    @(posedge clk); #1;
    main_ram_cs = 1'b0;
    main_vram_cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [21:0] exp3 [8];
  logic [31:0] got_w;
  bit          seen;
  int          exp_logs;

  initial begin
    rst = 1'b1;
    main_ram_cs = 1'b0; main_vram_cs = 1'b0; main_rnw = 1'b1;
    main_addr = '0; main_dsn = '0; main_dout = '0;
    dma_cs = 1'b0; dma_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_rd", 32'(ba0_rd), 32'd0);
    check("rst_wr", 32'(ba0_wr), 32'd0);
    check("rst_addr", 32'(ba0_addr), 32'd0);
    check("rst_main_ok", 32'(main_ok), 32'd0);
    check("rst_dma_ok", 32'(dma_ok), 32'd0);
    check("rst_data", 32'({main_data, dma_data}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: CPU read RAM 0x40, ack +2, rdy +4
    @(posedge clk); #1;
    ack_dly = 2; rdy_dly = 4; rd_val = 16'hBEEF;
    main_ram_cs = 1'b1; main_addr = 17'h40; main_rnw = 1'b1; main_dsn = 2'b00;
    wait_strobe("t1_strobe");
    check("t1_wr", 32'(ba0_wr), 32'd0);
    check("t1_addr", 32'(ba0_addr), 32'h10_0040);
    @(negedge clk); check("t1_rd_held", 32'(ba0_rd), 32'd1);
    @(negedge clk); check("t1_rd_drop", 32'(ba0_rd), 32'd0);
    @(negedge clk); check("t1_ok_early", 32'(main_ok), 32'd0);
    @(negedge clk); check("t1_ok", 32'(main_ok), 32'd1);
    check("t1_data", 32'(main_data), 32'hBEEF);
    @(posedge clk); #1 main_ram_cs = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t1_ok_clr", 32'(main_ok), 32'd0);

    // 2: CPU write VRAM
    ack_dly = 1; rdy_dly = 2;
    @(posedge clk); #1;
    main_vram_cs = 1'b1; main_addr = 17'h10; main_rnw = 1'b0;
    main_dsn = 2'b01; main_dout = 16'h1234;
    wait_strobe("t2_strobe");
    check("t2_wr", 32'(ba0_wr), 32'd1);
    check("t2_rd", 32'(ba0_rd), 32'd0);
    check("t2_addr", 32'(ba0_addr), 32'h12_0010);
    check("t2_mask", 32'(ba0_din_m), 32'd1);
    check("t2_din", 32'(ba0_din), 32'h1234);
    wait_main_ok("t2_ok");
    @(posedge clk); #1 main_vram_cs = 1'b0;
    repeat (3) @(negedge clk);

    // 3: continuous DMA with CPU pending, STARVE=3
    exp3 = '{22'h12_0200, 22'h12_0201, 22'h12_0202, 22'h10_0100,
             22'h12_0203, 22'h12_0204, 22'h12_0205, 22'h10_0101};
    log_q.delete();
    rd_val = 16'hA5A5;
    @(posedge clk); #1;
    main_ram_cs = 1'b1; main_addr = 17'h100; main_rnw = 1'b1; main_dsn = 2'b00;
    dma_cs = 1'b1; dma_addr = 17'h200;
    for (int c = 0; c < 300 && log_q.size() < 8; c++) begin
      @(posedge clk); #1;
      if (main_ok) main_addr = main_addr + 17'd1;
      if (dma_ok) dma_addr = dma_addr + 17'd1;
    end
    main_ram_cs = 1'b0; dma_cs = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      got_w = (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF;
      check($sformatf("t3_grant%0d", i), got_w, 32'(exp3[i]));
    end
    check("t3_dma_data", 32'(dma_data), 32'hA5A5);
    check("t3_dma_ok_clr", 32'(dma_ok), 32'd0);

    // 4: CPU drops cs during WAIT_RDY
    ack_dly = 1; rdy_dly = 4; rd_val = 16'h7777;
    @(posedge clk); #1;
    main_ram_cs = 1'b1; main_addr = 17'h300; main_rnw = 1'b1;
    wait_strobe("t4_strobe");
    @(negedge clk); check("t4_wait", 32'(ba0_rd), 32'd0);
    @(posedge clk); #1 main_ram_cs = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (main_ok) seen = 1'b1;
    end
    check("t4_no_ok", 32'(seen), 32'd0);
    check("t4_main_data", 32'(main_data), 32'hA5A5);
    check("t4_dma_data", 32'(dma_data), 32'hA5A5);
    ack_dly = 1; rdy_dly = 2; rd_val = 16'h1111;
    log_q.delete();
    do_cpu("t4_next_ok", 1'b0, 17'h301, 1'b1, 2'b00, 16'h0);
    check("t4_next_addr", (log_q.size() > 0) ? 32'(log_q[0]) : 32'hFFFF_FFFF, 32'h10_0301);
    check("t4_next_data", 32'(main_data), 32'h1111);

    // 5: reset while in REQ, then stray ack/rdy
    resp_en = 1'b0;
    @(posedge clk); #1;
    main_ram_cs = 1'b1; main_addr = 17'h400; main_rnw = 1'b1;
    wait_strobe("t5_strobe");
    rst = 1'b1;
    #1;
    check("t5_rd_async", 32'(ba0_rd), 32'd0);
    check("t5_ok", 32'(main_ok), 32'd0);
    check("t5_addr", 32'(ba0_addr), 32'd0);
    main_ram_cs = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    ba0_ack = 1'b1; ba0_rdy = 1'b1; data_read = 16'hDEAD;
    @(posedge clk); #1;
    ba0_ack = 1'b0; ba0_rdy = 1'b0; data_read = 16'h0;
    @(negedge clk); @(negedge clk);
    check("t5_stray_ok", 32'({main_ok, dma_ok, ba0_rd, ba0_wr}), 32'd0);
    check("t5_stray_data", 32'({main_data, dma_data}), 32'd0);
    resp_en = 1'b1;
    rd_val = 16'h2222;
    do_cpu("t5_recover_ok", 1'b0, 17'h401, 1'b1, 2'b00, 16'h0);
    check("t5_recover_data", 32'(main_data), 32'h2222);

    // ack and rdy in the same cycle, DMA alone
    ack_dly = 2; rdy_dly = 2; rd_val = 16'h3C3C;
    @(posedge clk); #1;
    dma_cs = 1'b1; dma_addr = 17'h50;
    wait_strobe("t7_strobe");
    check("t7_addr", 32'(ba0_addr), 32'h12_0050);
    @(negedge clk); check("t7_ok_early", 32'(dma_ok), 32'd0);
    @(negedge clk); check("t7_ok", 32'(dma_ok), 32'd1);
    check("t7_data", 32'(dma_data), 32'h3C3C);
    check("t7_idle", 32'(ba0_rd), 32'd0);
    @(posedge clk); #1 dma_cs = 1'b0;
    repeat (3) @(negedge clk);

    // 6: read twice, write, read again
    ack_dly = 1; rdy_dly = 2;
    log_q.delete();
    rd_val = 16'h4444;
    do_cpu("t6_rd1", 1'b0, 17'h40, 1'b1, 2'b00, 16'h0);
    check("t6_rd1_data", 32'(main_data), 32'h4444);
    rd_val = 16'h5555;
    do_cpu("t6_rd2", 1'b0, 17'h40, 1'b1, 2'b00, 16'h0);
`ifdef JTCPS2_BA0_CACHE_EN
    check("t6_rd2_data", 32'(main_data), 32'h4444);
    exp_logs = 3;
`else
    check("t6_rd2_data", 32'(main_data), 32'h5555);
    exp_logs = 4;
`endif
    do_cpu("t6_wr", 1'b0, 17'h40, 1'b0, 2'b00, 16'h9999);
    rd_val = 16'h6666;
    do_cpu("t6_rd3", 1'b0, 17'h40, 1'b1, 2'b00, 16'h0);
    check("t6_rd3_data", 32'(main_data), 32'h6666);
    check("t6_strobes", 32'(log_q.size()), 32'(exp_logs));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
